// File: rtl/mips_pkg.sv
// mips_pkg: shared op encodings, FSM states and iteration count for the HI/LO unit
package mips_pkg;
  localparam int ITER_COUNT = 32;
  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } md_op_e;
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10
  } md_state_e;
  function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? -v : v;
  endfunction
endpackage

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-cycle MIPS multiply/divide unit with HI/LO registers
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] WriteData,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);
  md_state_e r_state;
  md_op_e r_op;
  logic [4:0] r_cnt;
  logic [WIDTH-1:0] r_a, r_b, r_acc, r_q;
  logic w_signed, w_is_div, w_ge, w_neg, w_dz;
  logic [WIDTH-1:0] w_ma, w_mb, w_sub, w_quo, w_rem;
  logic [WIDTH:0] w_sum, w_shift;
  logic [2*WIDTH-1:0] w_prod;
  always_comb begin
    w_signed = (r_op == OP_MULT) || (r_op == OP_DIV);
    w_is_div = (r_op == OP_DIV) || (r_op == OP_DIVU);
    w_ma = mag(r_a, w_signed);
    w_mb = mag(r_b, w_signed);
    w_sum = {1'b0, r_acc} + {1'b0, r_q[0] ? w_ma : '0};
    w_shift = {r_acc, r_q[WIDTH-1]};
    w_ge = w_shift >= {1'b0, w_mb};
    w_sub = w_shift[WIDTH-1:0] - w_mb;
    w_neg = w_signed && (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
    w_dz = r_b == '0;
    w_prod = w_neg ? -{r_acc, r_q} : {r_acc, r_q};
    w_quo = w_neg ? -r_q : r_q;
    w_rem = (w_signed && r_a[WIDTH-1]) ? -r_acc : r_acc;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_op <= OP_MULT;
      r_cnt <= '0;
      r_a <= '0;
      r_b <= '0;
      r_acc <= '0;
      r_q <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      HI <= '0;
      LO <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_RUN;
            r_op <= md_op_e'(op);
            r_a <= SrcA;
            r_b <= WriteData;
            r_cnt <= '0;
            r_acc <= '0;
            r_q <= op[1] ? mag(SrcA, ~op[0]) : mag(WriteData, ~op[0]);
            busy <= 1'b1;
          end else begin
            if (mthi) HI <= SrcA;
            if (mtlo) LO <= SrcA;
          end
        end
        // multiply shifts {acc,q} right after adding; divide shifts left and restores
        S_RUN: begin
          r_acc <= w_is_div ? (w_ge ? w_sub : w_shift[WIDTH-1:0]) : w_sum[WIDTH:1];
          r_q <= w_is_div ? {r_q[WIDTH-2:0], w_ge} : {w_sum[0], r_q[WIDTH-1:1]};
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'(ITER_COUNT - 1)) r_state <= S_FIX;
        end
        S_FIX: begin
          HI <= !w_is_div ? w_prod[2*WIDTH-1:WIDTH] : (w_dz ? r_a : w_rem);
          LO <= !w_is_div ? w_prod[WIDTH-1:0] : (w_dz ? '1 : w_quo);
          done <= 1'b1;
          busy <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed-vector bench for the iterative multiply/divide unit
module tb_mult_div_unit;
  logic clk = 1'b0;
  logic reset, start, mthi, mtlo, busy, done;
  logic [1:0] op;
  logic [31:0] SrcA, WriteData, HI, LO;
  int pass = 0;
  int total = 0;
  always #5 clk = ~clk;
  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .SrcA(SrcA),
    .WriteData(WriteData), .mthi(mthi), .mtlo(mtlo), .busy(busy),
    .done(done), .HI(HI), .LO(LO)
  );
  // presents start during cycle E; returns at the falling edge of cycle E+1
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    op = o;
    SrcA = a;
    WriteData = b;
    @(negedge clk);
    start = 1'b0;
  endtask
  // n counts cycles from entry; returns in the done cycle (lat = n) or lat = -1 on timeout
  task automatic wait_done(output int lat, output int busy_bad);
    lat = -1;
    busy_bad = 0;
    for (int n = 1; n <= 60; n++) begin
      if (done) begin
        lat = n;
        if (busy) busy_bad++;
        break;
      end
      if (!busy) busy_bad++;
      @(negedge clk);
    end
  endtask
  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    mthi = 1'b0;
    mtlo = 1'b0;
    op = 2'b00;
    SrcA = '0;
    WriteData = '0;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done, HI, LO} !== 66'd0) $display("FAIL reset_state busy=%b done=%b HI=%h LO=%h required all 0", busy, done, HI, LO);
    else pass++;
    reset = 1'b0;
  endtask
  task automatic test_mult;
    int lat, bb;
    issue(2'b00, 32'hFFFFFFFE, 32'h00000003);
    wait_done(lat, bb);
    total++;
    if (lat !== 34) $display("FAIL mult_latency done at E+%0d required E+34", lat);
    else pass++;
    total++;
    if (bb !== 0) $display("FAIL mult_busy %0d bad busy cycles required 0", bb);
    else pass++;
    total++;
    if ({HI, LO} !== 64'hFFFFFFFF_FFFFFFFA) $display("FAIL mult_result HI=%h LO=%h required FFFFFFFF FFFFFFFA", HI, LO);
    else pass++;
    @(negedge clk);
    total++;
    if (done !== 1'b0) $display("FAIL mult_done_pulse done=%b in E+35 required 0", done);
    else pass++;
  endtask
  task automatic test_multu;
    int lat, bb;
    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(lat, bb);
    total++;
    if ({HI, LO} !== 64'hFFFFFFFE_00000001 || lat !== 34) $display("FAIL multu_result HI=%h LO=%h lat=%0d required FFFFFFFE 00000001 34", HI, LO, lat);
    else pass++;
  endtask
  task automatic test_div;
    int lat, bb;
    issue(2'b10, 32'hFFFFFFF9, 32'h00000002);
    wait_done(lat, bb);
    total++;
    if ({HI, LO} !== 64'hFFFFFFFF_FFFFFFFD || lat !== 34) $display("FAIL div_neg HI=%h LO=%h lat=%0d required FFFFFFFF FFFFFFFD 34", HI, LO, lat);
    else pass++;
    issue(2'b11, 32'h00000007, 32'h00000000);
    wait_done(lat, bb);
    total++;
    if ({HI, LO} !== 64'h00000007_FFFFFFFF) $display("FAIL divu_zero HI=%h LO=%h required 00000007 FFFFFFFF", HI, LO);
    else pass++;
    issue(2'b10, 32'hFFFFFFF9, 32'h00000000);
    wait_done(lat, bb);
    total++;
    if ({HI, LO} !== 64'hFFFFFFF9_FFFFFFFF) $display("FAIL div_zero_signed HI=%h LO=%h required FFFFFFF9 FFFFFFFF", HI, LO);
    else pass++;
  endtask
  task automatic test_back_to_back;
    int lat, bb;
    issue(2'b10, 32'h80000000, 32'hFFFFFFFF);
    wait_done(lat, bb);
    total++;
    if ({HI, LO} !== 64'h00000000_80000000) $display("FAIL div_overflow HI=%h LO=%h required 00000000 80000000", HI, LO);
    else pass++;
    start = 1'b1;
    op = 2'b11;
    SrcA = 32'd100;
    WriteData = 32'd7;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b1) $display("FAIL b2b_accept busy=%b required 1", busy);
    else pass++;
    wait_done(lat, bb);
    total++;
    if ({HI, LO} !== {32'd2, 32'd14} || lat !== 34) $display("FAIL b2b_result HI=%h LO=%h lat=%0d required 00000002 0000000e 34", HI, LO, lat);
    else pass++;
  endtask
  task automatic test_abort;
    int seen = 0;
    issue(2'b01, 32'h00001234, 32'h00005678);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if ({busy, HI, LO} !== 65'd0) $display("FAIL abort_state busy=%b HI=%h LO=%h required 0 0 0", busy, HI, LO);
    else pass++;
    for (int n = 0; n < 40; n++) begin
      if (done) seen++;
      @(negedge clk);
    end
    total++;
    if (seen !== 0) $display("FAIL abort_no_done %0d done pulses required 0", seen);
    else pass++;
  endtask
  task automatic test_operand_hold;
    int lat, bb;
    issue(2'b10, 32'd100, 32'hFFFFFFF9);
    repeat (4) @(negedge clk);
    op = 2'b01;
    SrcA = 32'd3;
    WriteData = 32'd4;
    wait_done(lat, bb);
    total++;
    if ({HI, LO} !== 64'h00000002_FFFFFFF2 || lat !== 30) $display("FAIL operand_hold HI=%h LO=%h lat=%0d required 00000002 FFFFFFF2 30", HI, LO, lat);
    else pass++;
  endtask
  task automatic test_mthi_mtlo;
    @(negedge clk);
    mthi = 1'b1;
    mtlo = 1'b1;
    SrcA = 32'h12345678;
    @(negedge clk);
    mthi = 1'b0;
    mtlo = 1'b0;
    total++;
    if ({HI, LO} !== 64'h12345678_12345678 || done !== 1'b0) $display("FAIL mthi_mtlo HI=%h LO=%h done=%b required 12345678 12345678 0", HI, LO, done);
    else pass++;
    SrcA = 32'h0000ABCD;
    mtlo = 1'b1;
    @(negedge clk);
    mtlo = 1'b0;
    total++;
    if ({HI, LO} !== 64'h12345678_0000ABCD) $display("FAIL mtlo_only HI=%h LO=%h required 12345678 0000abcd", HI, LO);
    else pass++;
  endtask
  task automatic test_start_priority;
    int lat, bb;
    @(negedge clk);
    start = 1'b1;
    mthi = 1'b1;
    mtlo = 1'b1;
    op = 2'b01;
    SrcA = 32'd7;
    WriteData = 32'd6;
    @(negedge clk);
    start = 1'b0;
    mthi = 1'b0;
    mtlo = 1'b0;
    total++;
    if ({HI, LO} !== 64'h12345678_0000ABCD) $display("FAIL start_wins HI=%h LO=%h required 12345678 0000abcd", HI, LO);
    else pass++;
    repeat (2) @(negedge clk);
    mthi = 1'b1;
    SrcA = 32'hDEADBEEF;
    wait_done(lat, bb);
    total++;
    if ({HI, LO} !== {32'd0, 32'd42} || lat !== 32) $display("FAIL mthi_busy HI=%h LO=%h lat=%0d required 00000000 0000002a 32", HI, LO, lat);
    else pass++;
    mthi = 1'b0;
  endtask
  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_back_to_back();
    test_abort();
    test_operand_hold();
    test_mthi_mtlo();
    test_start_priority();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
